frv_clmul_seq: RTL

//  Iterative carry-less multiplier for the execute stage; XLEN-generic

---
 rtl/frv_clmul_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/frv_clmul_seq.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr), BPC multiplier bits per cycle,
// with request/response handshake, optional early-out and flush.
module frv_clmul_seq #(
   parameter int XLEN      = 32,
   parameter int BPC       = 4,
   parameter int EARLY_OUT = 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            op_clmul,
   input  logic            op_clmulh,
   input  logic            op_clmulr,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            rsp_valid,
   input  logic            rsp_ack,
   output logic [XLEN-1:0] result
);

   localparam int STEPS = XLEN / BPC;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {OP_CLMUL, OP_CLMULH, OP_CLMULR} op_t;

   state_t            state_q, state_d;
   op_t               op_q, op_d;
   logic [2*XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic [2*XLEN-1:0] step_acc;
   logic [2*XLEN-1:0] step_a;
   logic [XLEN-1:0]   step_b;
   logic [CW-1:0]     step_cnt;
   logic              step_last;
   logic [XLEN-1:0]   step_res;

   // One RUN step: fold in BPC partial products, then advance both operands.
   always_comb begin
      step_acc = acc_q;
      for (int j = 0; j < BPC; j++) begin
         if (b_q[j]) step_acc = step_acc ^ (a_q << j);
      end
      step_a    = a_q << BPC;
      step_b    = b_q >> BPC;
      step_cnt  = cnt_q + 1'b1;
      step_last = (step_cnt == CW'(STEPS)) || ((EARLY_OUT != 0) && (step_b == '0));
      case (op_q)
         OP_CLMULR: step_res = step_acc[2*XLEN-2:XLEN-1];
         OP_CLMULH: step_res = step_acc[2*XLEN-1:XLEN];
         default:   step_res = step_acc[XLEN-1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_RUN;
               if (op_clmulr)      op_d = OP_CLMULR;
               else if (op_clmulh) op_d = OP_CLMULH;
               else                op_d = OP_CLMUL;
               a_d   = {{XLEN{1'b0}}, rs1};
               b_d   = rs2;
               acc_d = '0;
               cnt_d = '0;
            end
         end
         S_RUN: begin
            acc_d = step_acc;
            a_d   = step_a;
            b_d   = step_b;
            cnt_d = step_cnt;
            if (step_last) begin
               state_d = S_DONE;
               res_d   = step_res;
            end
         end
         S_DONE: begin
            if (rsp_ack) begin
               state_d = S_IDLE;
               res_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // result must read zero whenever no response is being offered
      if (flush) begin
         state_d = S_IDLE;
         res_d   = '0;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_CLMUL;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   assign req_ready = (state_q == S_IDLE) && !g_reset;
   assign rsp_valid = (state_q == S_DONE);
   assign result    = res_q;

endmodule
